frame_extrema_tracker: RTL and testbench
========================================

Name: frame_extrema_tracker

Overview:
- Streaming stage directly downstream of the magnitude comparator. Consumes a sample stream framed by a last flag, one sample per accepted beat.
- Per frame, tracks running maximum, running minimum, index of the maximum, and sample count. Compares in signed or unsigned mode.
- Presents one result record per frame on a valid/ready output. All greater-than decisions come from one comparator sub-module instantiated twice.

Parameters:
WIDTH, 8, sample width in bits
CNT_W, 16, width of sample count and index fields

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
mode  in  1  1 = signed two's-complement compare, 0 = unsigned; sampled on first beat of a frame
in_valid  in  1  input sample valid
in_ready  out  1  block can accept a sample
in_data  in  WIDTH  sample value
in_last  in  1  sample is the final one of its frame
out_valid  out  1  result record valid
out_ready  in  1  downstream accepts result
out_max  out  WIDTH  frame maximum
out_min  out  WIDTH  frame minimum
out_max_idx  out  CNT_W  zero-based index of first occurrence of maximum
out_count  out  CNT_W  samples in frame (saturating)
out_sat  out  1  frame length exceeded 2^CNT_W-1

Behaviour:
- One clock domain. Reset is asynchronous and active-low; clk and rst_n as named above.
- Reset values: state=IDLE, out_valid=0, in_ready=1, out_max=0, out_min=0, out_max_idx=0, out_count=0, out_sat=0, latched mode=0.
- Accept rule: a beat is accepted when in_valid && in_ready.
- in_ready = 1 in IDLE and ACCUM, 0 in HOLD. It is a registered state decode with no combinational path from out_ready.
- IDLE, on accept (first beat):
  - max=min=in_data, max_idx=0, count=1, sat=0; latch mode.
  - in_last=1 -> HOLD (single-sample frame); else -> ACCUM.
- ACCUM, on accept:
  - Compare in_data against current max and current min using the latched mode.
  - in_data > max (strict) -> max=in_data, max_idx=count.
  - min > in_data (strict) -> min=in_data.
  - Ties never update, so max_idx reports the earliest occurrence.
  - count increments. At 2^CNT_W-1 count holds and sat=1; max_idx stops advancing but compares continue.
  - in_last=1 -> HOLD.
- HOLD:
  - out_valid=1. out_* fields are stable and equal to the final frame values.
  - out_valid && out_ready -> IDLE. out_valid drops the next cycle.
- Latency: the result is valid the cycle after the last beat is accepted.
- Throughput: one sample per cycle within a frame. There is at least one bubble cycle between frames: HOLD lasts ≥1 cycle and in_ready=0 there.
- No accept in a cycle leaves state and registers unchanged.
- mode changes mid-frame are ignored until the next first beat.
- Signed compare: the sign bit is treated as weight -2^(WIDTH-1). Unsigned compare is a plain magnitude compare.
- The sub-module is purely combinational. All state lives in this block.
- Reset asserted mid-frame or in HOLD: immediate return to reset values. The partial frame is discarded; there is no output record.
- out_* hold their last values after the handshake, but are meaningful only while out_valid=1.

Decomposition:
- Shared package:
  - state enumeration (IDLE, ACCUM, HOLD) as a 2-bit type;
  - mode encoding constants MODE_UNSIGNED=0, MODE_SIGNED=1;
  - default WIDTH/CNT_W constants.
- One sub-module: gt_compare (parameter WIDTH; inputs a, b, mode; output agtb).
  - It gives a correct signed path by inverting the MSBs before an unsigned compare.
  - It is instantiated twice: (in_data, max) and (min, in_data).

Test Plan:
- Signed frame, WIDTH=8, mode=1, samples 0x7F,0x80,0x05 (last on 0x05) -> one record: max=0x7F, min=0x80, max_idx=0, count=3, sat=0.
- Same three samples, mode=0 -> max=0x80, min=0x05, max_idx=1, count=3.
- Ties, mode=0, samples 3,7,7,1 -> max=7, max_idx=1, min=1, count=4.
- Single-sample frame 0x42 with last=1 -> out_valid the next cycle: max=min=0x42, max_idx=0, count=1.
- Backpressure: hold out_ready=0 for 5 cycles after result -> out_valid stays 1 with stable fields, in_ready=0 throughout. out_ready=1 -> out_valid=0 and in_ready=1 the next cycle. The next frame is then processed correctly.
- Saturation and reset:
  - CNT_W=4, 20-sample frame -> count=15, sat=1.
  - rst_n pulsed low mid-frame -> all outputs at reset values, no record emitted.
  - A following 2-sample frame reports count=2.

Source files
------------

// File: rtl/frame_extrema_tracker_pkg.sv
`default_nettype none
// ============================================================================
// Module      : frame_extrema_tracker_pkg
// Description : Shared types and constants for the frame extrema tracker.
// Revision    : 1.0 - initial release
// ============================================================================
package frame_extrema_tracker_pkg;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_CNT_W = 16;

   localparam logic MODE_UNSIGNED = 1'b0;
   localparam logic MODE_SIGNED   = 1'b1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_t;

endpackage : frame_extrema_tracker_pkg
`default_nettype wire

// File: rtl/frame_extrema_tracker_gt_compare.sv
`default_nettype none
// ============================================================================
// Module      : gt_compare
// Description : Strict a > b in unsigned or two's-complement mode.
// Revision    : 1.0 - initial release
// ============================================================================
module gt_compare
   import frame_extrema_tracker_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             mode,
   output logic             agtb
);

   logic [WIDTH-1:0] w_bias;
   logic [WIDTH-1:0] w_a;
   logic [WIDTH-1:0] w_b;

   // Flipping the sign bit maps two's-complement order onto unsigned order.
   assign w_bias = {(mode == MODE_SIGNED), {(WIDTH-1){1'b0}}};
   assign w_a    = a ^ w_bias;
   assign w_b    = b ^ w_bias;
   assign agtb   = (w_a > w_b);

endmodule : gt_compare
`default_nettype wire

// File: rtl/frame_extrema_tracker.sv
`default_nettype none
// ============================================================================
// Module      : frame_extrema_tracker
// Description : Per-frame max/min/argmax/count tracker with valid/ready I/O.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_extrema_tracker
   import frame_extrema_tracker_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             mode,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_max,
   output logic [WIDTH-1:0] out_min,
   output logic [CNT_W-1:0] out_max_idx,
   output logic [CNT_W-1:0] out_count,
   output logic             out_sat
);

   localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

   state_t           r_state;
   logic             r_mode;
   logic             r_in_ready;
   logic             r_out_valid;
   logic [WIDTH-1:0] r_max;
   logic [WIDTH-1:0] r_min;
   logic [CNT_W-1:0] r_max_idx;
   logic [CNT_W-1:0] r_count;
   logic             r_sat;

   logic             w_accept;
   logic             w_new_max;
   logic             w_new_min;

   assign w_accept = in_valid && r_in_ready;

   gt_compare #(
      .WIDTH (WIDTH)
   ) u_gt_max (
      .a    (in_data),
      .b    (r_max),
      .mode (r_mode),
      .agtb (w_new_max)
   );

   gt_compare #(
      .WIDTH (WIDTH)
   ) u_gt_min (
      .a    (r_min),
      .b    (in_data),
      .mode (r_mode),
      .agtb (w_new_min)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_mode      <= MODE_UNSIGNED;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_max       <= '0;
         r_min       <= '0;
         r_max_idx   <= '0;
         r_count     <= '0;
         r_sat       <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_max     <= in_data;
                  r_min     <= in_data;
                  r_max_idx <= '0;
                  r_count   <= C_CNT_ONE;
                  r_sat     <= 1'b0;
                  r_mode    <= mode;
                  if (in_last) begin
                     r_state     <= HOLD;
                     r_in_ready  <= 1'b0;
                     r_out_valid <= 1'b1;
                  end else begin
                     r_state <= ACCUM;
                  end
               end
            end

            ACCUM: begin
               if (w_accept) begin
                  // r_count is the zero-based index of the incoming sample.
                  if (w_new_max) begin
                     r_max     <= in_data;
                     r_max_idx <= r_count;
                  end
                  if (w_new_min) begin
                     r_min <= in_data;
                  end
                  if (r_count == C_CNT_MAX) begin
                     r_sat <= 1'b1;
                  end else begin
                     r_count <= r_count + C_CNT_ONE;
                  end
                  if (in_last) begin
                     r_state     <= HOLD;
                     r_in_ready  <= 1'b0;
                     r_out_valid <= 1'b1;
                  end
               end
            end

            HOLD: begin
               if (out_ready) begin
                  r_state     <= IDLE;
                  r_in_ready  <= 1'b1;
                  r_out_valid <= 1'b0;
               end
            end

            default: begin
               r_state     <= IDLE;
               r_in_ready  <= 1'b1;
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready    = r_in_ready;
   assign out_valid   = r_out_valid;
   assign out_max     = r_max;
   assign out_min     = r_min;
   assign out_max_idx = r_max_idx;
   assign out_count   = r_count;
   assign out_sat     = r_sat;

endmodule : frame_extrema_tracker
`default_nettype wire

// File: tb/tb_frame_extrema_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tb_frame_extrema_tracker
// Description : Self-checking bench: directed and random frames vs a model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_extrema_tracker;

   typedef struct {
      logic [7:0] mx;
      logic [7:0] mn;
      int         idx;
      int         cnt;
      logic       sat;
   } rec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;

   // Main instance (CNT_W=16)
   logic        mode = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  in_data = '0;
   logic        in_last = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [7:0]  out_max;
   logic [7:0]  out_min;
   logic [15:0] out_max_idx;
   logic [15:0] out_count;
   logic        out_sat;

   // Small-counter instance (CNT_W=4) for saturation
   logic        s_mode = 1'b0;
   logic        s_in_valid = 1'b0;
   logic        s_in_ready;
   logic [7:0]  s_in_data = '0;
   logic        s_in_last = 1'b0;
   logic        s_out_valid;
   logic        s_out_ready = 1'b0;
   logic [7:0]  s_out_max;
   logic [7:0]  s_out_min;
   logic [3:0]  s_out_max_idx;
   logic [3:0]  s_out_count;
   logic        s_out_sat;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   frame_extrema_tracker #(.WIDTH(8), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
      .out_max(out_max), .out_min(out_min), .out_max_idx(out_max_idx),
      .out_count(out_count), .out_sat(out_sat)
   );

   frame_extrema_tracker #(.WIDTH(8), .CNT_W(4)) dut_s (
      .clk(clk), .rst_n(rst_n), .mode(s_mode), .in_valid(s_in_valid), .in_ready(s_in_ready),
      .in_data(s_in_data), .in_last(s_in_last), .out_valid(s_out_valid), .out_ready(s_out_ready),
      .out_max(s_out_max), .out_min(s_out_min), .out_max_idx(s_out_max_idx),
      .out_count(s_out_count), .out_sat(s_out_sat)
   );

   // Reference: plain integer interpretation of each sample, first-occurrence argmax.
   function automatic rec_t ref_model(input logic [7:0] q[$], input logic m, input int cmax);
      rec_t r;
      int   best;
      int   worst;
      int   v;
      best  = 0;
      worst = 0;
      r     = '{mx: 8'h00, mn: 8'h00, idx: 0, cnt: 0, sat: 1'b0};
      for (int i = 0; i < q.size(); i++) begin
         v = m ? int'($signed(q[i])) : int'(q[i]);
         if (i == 0 || v > best) begin
            best  = v;
            r.mx  = q[i];
            r.idx = (i > cmax) ? cmax : i;
         end
         if (i == 0 || v < worst) begin
            worst = v;
            r.mn  = q[i];
         end
      end
      r.cnt = (q.size() > cmax) ? cmax : q.size();
      r.sat = (q.size() > cmax);
      return r;
   endfunction

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if ({out_valid, in_ready, out_max, out_min, out_max_idx, out_count, out_sat} !==
          {1'b0, 1'b1, 8'h00, 8'h00, 16'h0000, 16'h0000, 1'b0}) begin
         n_err++;
         $display("FAIL reset_main: got v=%b r=%b max=%h min=%h idx=%0d cnt=%0d sat=%b, want v=0 r=1 rest 0",
                  out_valid, in_ready, out_max, out_min, out_max_idx, out_count, out_sat);
      end
      n_cmp++;
      if ({s_out_valid, s_in_ready, s_out_count, s_out_sat} !== {1'b0, 1'b1, 4'h0, 1'b0}) begin
         n_err++;
         $display("FAIL reset_small: got v=%b r=%b cnt=%0d sat=%b, want v=0 r=1 cnt=0 sat=0",
                  s_out_valid, s_in_ready, s_out_count, s_out_sat);
      end
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // Drives one frame into the main instance, checks the record and the handshake.
   task automatic run_frame(input string name, input logic [7:0] q[$], input logic m,
                            input rec_t exp, input int max_gap, input int hold);
      int n;
      int g;
      int guard;
      n = q.size();
      for (int i = 0; i < n; i++) begin
         g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
         in_valid = 1'b0;
         repeat (g) begin @(posedge clk); #1; end
         in_valid = 1'b1;
         in_data  = q[i];
         in_last  = (i == n - 1);
         mode     = (i == 0) ? m : 1'($urandom);
         guard    = 0;
         while (!in_ready && guard < 50) begin @(posedge clk); #1; guard++; end
         if (guard >= 50) begin
            n_cmp++; n_err++;
            $display("FAIL %s_in_ready_timeout: in_ready=%b, want 1", name, in_ready);
         end
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         in_last  = 1'b0;
         mode     = 1'($urandom);
      end
      n_cmp++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
         n_err++;
         $display("FAIL %s_latency: got out_valid=%b in_ready=%b, want 1 0", name, out_valid, in_ready);
      end
      n_cmp++;
      if (out_max !== exp.mx) begin
         n_err++; $display("FAIL %s_max: got %h want %h", name, out_max, exp.mx);
      end
      n_cmp++;
      if (out_min !== exp.mn) begin
         n_err++; $display("FAIL %s_min: got %h want %h", name, out_min, exp.mn);
      end
      n_cmp++;
      if (out_max_idx !== 16'(exp.idx)) begin
         n_err++; $display("FAIL %s_idx: got %0d want %0d", name, out_max_idx, exp.idx);
      end
      n_cmp++;
      if (out_count !== 16'(exp.cnt) || out_sat !== exp.sat) begin
         n_err++;
         $display("FAIL %s_count: got cnt=%0d sat=%b want cnt=%0d sat=%b", name, out_count, out_sat, exp.cnt, exp.sat);
      end
      out_ready = 1'b0;
      for (int c = 0; c < hold; c++) begin
         @(posedge clk);
         #1;
         n_cmp++;
         if ({out_valid, in_ready, out_max, out_min, out_max_idx, out_count} !==
             {1'b1, 1'b0, exp.mx, exp.mn, 16'(exp.idx), 16'(exp.cnt)}) begin
            n_err++;
            $display("FAIL %s_hold%0d: got v=%b r=%b max=%h min=%h idx=%0d cnt=%0d, want v=1 r=0 max=%h min=%h idx=%0d cnt=%0d",
                     name, c, out_valid, in_ready, out_max, out_min, out_max_idx, out_count,
                     exp.mx, exp.mn, exp.idx, exp.cnt);
         end
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      n_cmp++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL %s_release: got out_valid=%b in_ready=%b, want 0 1", name, out_valid, in_ready);
      end
   endtask

   task automatic test_signed();
      logic [7:0] q[$];
      q = '{8'h7F, 8'h80, 8'h05};
      run_frame("signed", q, 1'b1, '{mx: 8'h7F, mn: 8'h80, idx: 0, cnt: 3, sat: 1'b0}, 0, 0);
   endtask

   task automatic test_unsigned();
      logic [7:0] q[$];
      q = '{8'h7F, 8'h80, 8'h05};
      run_frame("unsigned", q, 1'b0, '{mx: 8'h80, mn: 8'h05, idx: 1, cnt: 3, sat: 1'b0}, 1, 1);
   endtask

   task automatic test_ties();
      logic [7:0] q[$];
      q = '{8'd3, 8'd7, 8'd7, 8'd1};
      run_frame("ties", q, 1'b0, '{mx: 8'd7, mn: 8'd1, idx: 1, cnt: 4, sat: 1'b0}, 0, 0);
   endtask

   task automatic test_single();
      logic [7:0] q[$];
      q = '{8'h42};
      run_frame("single", q, 1'($urandom), '{mx: 8'h42, mn: 8'h42, idx: 0, cnt: 1, sat: 1'b0}, 0, 0);
   endtask

   task automatic test_back_to_back();
      logic [7:0] q[$];
      q = '{8'd10, 8'd20, 8'd5};
      run_frame("backpressure", q, 1'b0, '{mx: 8'd20, mn: 8'd5, idx: 1, cnt: 3, sat: 1'b0}, 0, 5);
      q = '{8'hFF, 8'h00};
      run_frame("after_bp", q, 1'b1, '{mx: 8'h00, mn: 8'hFF, idx: 1, cnt: 2, sat: 1'b0}, 0, 0);
   endtask

   task automatic test_random();
      logic [7:0] q[$];
      logic       m;
      int         len;
      for (int f = 0; f < 30; f++) begin
         q.delete();
         len = int'($urandom_range(12, 1));
         m   = 1'($urandom);
         for (int i = 0; i < len; i++) begin
            // Narrow value set in some frames to provoke ties.
            if (f % 3 == 0) q.push_back(8'($urandom_range(3, 0)) + 8'hFE);
            else            q.push_back(8'($urandom));
         end
         run_frame($sformatf("rand%0d", f), q, m, ref_model(q, m, 65535), 2, int'($urandom_range(3, 0)));
      end
   endtask

   task automatic test_saturation();
      logic [7:0] q[$];
      logic       m;
      rec_t       e;
      int         lens[2];
      lens[0] = 20;
      lens[1] = 15;
      for (int t = 0; t < 2; t++) begin
         q.delete();
         m = 1'($urandom);
         for (int i = 0; i < lens[t]; i++) q.push_back(8'($urandom));
         e = ref_model(q, m, 15);
         for (int i = 0; i < lens[t]; i++) begin
            s_in_valid = 1'b1;
            s_in_data  = q[i];
            s_in_last  = (i == lens[t] - 1);
            s_mode     = (i == 0) ? m : 1'($urandom);
            @(posedge clk);
            #1;
         end
         s_in_valid = 1'b0;
         s_in_last  = 1'b0;
         n_cmp++;
         if (s_out_valid !== 1'b1 || s_out_count !== 4'd15 || s_out_sat !== (t == 0)) begin
            n_err++;
            $display("FAIL sat_len%0d: got v=%b cnt=%0d sat=%b want v=1 cnt=15 sat=%b",
                     lens[t], s_out_valid, s_out_count, s_out_sat, (t == 0));
         end
         n_cmp++;
         if (s_out_max !== e.mx || s_out_min !== e.mn || s_out_max_idx !== 4'(e.idx)) begin
            n_err++;
            $display("FAIL sat_fields_len%0d: got max=%h min=%h idx=%0d want max=%h min=%h idx=%0d",
                     lens[t], s_out_max, s_out_min, s_out_max_idx, e.mx, e.mn, e.idx);
         end
         s_out_ready = 1'b1;
         @(posedge clk);
         #1;
         s_out_ready = 1'b0;
      end
   endtask

   task automatic test_reset_midframe();
      logic [7:0] q[$];
      int         seen;
      mode = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_data  = 8'h11 * 8'(i + 1);
         in_last  = 1'b0;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({out_valid, in_ready, out_max, out_min, out_max_idx, out_count, out_sat} !==
          {1'b0, 1'b1, 8'h00, 8'h00, 16'h0000, 16'h0000, 1'b0}) begin
         n_err++;
         $display("FAIL midframe_reset: got v=%b r=%b max=%h min=%h idx=%0d cnt=%0d sat=%b, want v=0 r=1 rest 0",
                  out_valid, in_ready, out_max, out_min, out_max_idx, out_count, out_sat);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      seen  = 0;
      repeat (4) begin
         @(posedge clk);
         #1;
         if (out_valid !== 1'b0) seen++;
      end
      n_cmp++;
      if (seen != 0) begin
         n_err++;
         $display("FAIL midframe_no_record: out_valid high %0d cycles, want 0", seen);
      end
      q = '{8'h30, 8'h20};
      run_frame("post_reset", q, 1'b0, '{mx: 8'h30, mn: 8'h20, idx: 0, cnt: 2, sat: 1'b0}, 0, 0);
   endtask

   initial begin
      test_reset();
      test_signed();
      test_unsigned();
      test_ties();
      test_single();
      test_back_to_back();
      test_random();
      test_saturation();
      test_reset_midframe();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

endmodule : tb_frame_extrema_tracker
`default_nettype wire
